// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 width/sign codes used by RV32I loads and stores
//   - FSM state encoding
//   - legality helpers evaluated on the effective address at start
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Halfwords need ea[0]=0, words need ea[1:0]=0; bytes are always aligned.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
        logic m;
        m = 1'b0;
        case (f3[1:0])
            2'b01:   m = ea_lo[0];
            2'b10:   m = |ea_lo;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Stores have no unsigned variants, so any funct3[2]=1 is rejected.
    function automatic logic illegal_f3(input logic st, input logic [2:0] f3);
        logic bad;
        if (st)
            bad = f3[2] || (f3[1:0] == 2'b11);
        else
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational.
//   funct3      in   access width/sign code
//   ea_lo       in   effective address bits [1:0]
//   store_data  in   rs2 value
//   mem_rdata   in   read data word from the bus
//   wstrb       out  byte strobes for the store
//   wdata       out  replicated store data
//   load_value  out  extracted, sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << ea_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << {ea_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = 32'h0;
            end
        endcase
    end

    always_comb begin
        lane_b     = mem_rdata[{ea_lo, 3'b000} +: 8];
        lane_h     = mem_rdata[{ea_lo[1], 4'b0000} +: 16];
        load_value = 32'h0;
        case (funct3)
            F3_B:    load_value = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_value = {{16{lane_h[15]}}, lane_h};
            F3_W:    load_value = mem_rdata;
            F3_BU:   load_value = {24'h0, lane_b};
            F3_HU:   load_value = {16'h0, lane_h};
            default: load_value = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store engine: one aligned word access per request over a
// req/ready + rvalid bus, with load results written back to the register file.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; latches ea/controls on start
//   REQ   | mem_req high, address/strobes/data held until mem_ready
//   WAIT  | load accepted, waiting for mem_rvalid
//   DONE  | one-cycle done pulse (+ rd write for successful loads)
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   start, is_store, funct3  request pulse and access type
//   base, imm, store_data    rs1, offset, rs2
//   rd_in                    load destination register
//   busy, done, err          status; err is valid with done
//   rd_we, rd_addr, rd_data  register file write port
//   mem_*                    data memory bus
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Last counter value before abort: the access gets 2**TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] TC_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    lsu_state_t           state_q, state_d;
    logic [31:0]          ea_q;
    logic                 st_q;
    logic [2:0]           f3_q;
    logic [31:0]          sd_q;
    logic [4:0]           rd_q;
    logic [31:0]          rdata_q;
    logic                 err_q;
    logic [TIMEOUT_W-1:0] cnt_q;

    logic [31:0]          ea;
    logic                 bad;
    logic                 timeout;
    logic [3:0]           al_wstrb;
    logic [31:0]          al_wdata;
    logic [31:0]          al_load;

    assign ea  = base + imm;
    assign bad = misaligned(funct3, ea[1:0]) || illegal_f3(is_store, funct3);

    lsu_align u_align (
        .funct3     (f3_q),
        .ea_lo      (ea_q[1:0]),
        .store_data (sd_q),
        .mem_rdata  (rdata_q),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_value (al_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ea_q    <= 32'h0;
            st_q    <= 1'b0;
            f3_q    <= 3'b000;
            sd_q    <= 32'h0;
            rd_q    <= 5'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ea_q    <= ea;
                        st_q    <= is_store;
                        f3_q    <= funct3;
                        sd_q    <= store_data;
                        rd_q    <= rd_in;
                        rdata_q <= 32'h0;
                        err_q   <= bad;
                        cnt_q   <= '0;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + TIMEOUT_W'(1);
                    // Read data may return in the same cycle as acceptance.
                    if (mem_ready && mem_rvalid && !st_q)
                        rdata_q <= mem_rdata;
                    if (timeout)
                        err_q <= 1'b1;
                end
                WAIT: begin
                    cnt_q <= cnt_q + TIMEOUT_W'(1);
                    if (mem_rvalid)
                        rdata_q <= mem_rdata;
                    if (timeout)
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Completion beats timeout when both happen in the same cycle.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = bad ? DONE : REQ;
            end
            REQ: begin
                if (mem_ready)
                    state_d = (st_q || mem_rvalid) ? DONE : WAIT;
                else if (cnt_q == TC_LAST) begin
                    state_d = DONE;
                    timeout = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid)
                    state_d = DONE;
                else if (cnt_q == TC_LAST) begin
                    state_d = DONE;
                    timeout = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        err       = (state_q == DONE) && err_q;
        mem_req   = (state_q == REQ);
        mem_we    = (state_q == REQ) && st_q;
        mem_addr  = (state_q == REQ) ? {ea_q[31:2], 2'b00} : 32'h0;
        mem_wstrb = (state_q == REQ && st_q) ? al_wstrb : 4'b0000;
        mem_wdata = (state_q == REQ && st_q) ? al_wdata : 32'h0;
        rd_addr   = rd_q;
        rd_data   = 32'h0;
        rd_we     = 1'b0;
        if (state_q == DONE && !err_q && !st_q) begin
            rd_data = al_load;
            rd_we   = (rd_q != 5'd0);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk;
    int n_pass;

    load_store_unit #(.TIMEOUT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .base       (base),
        .imm        (imm),
        .store_data (store_data),
        .rd_in      (rd_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_we      (rd_we),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one access with a simple bus responder and reports what was seen.
    // rdy_dly: REQ cycles before mem_ready (negative = never).
    // vld_dly: cycles after acceptance before mem_rvalid (0 = same cycle).
    task automatic run_access(
        input  logic        st,
        input  logic [2:0]  f3,
        input  logic [31:0] b,
        input  logic [31:0] i,
        input  logic [31:0] sd,
        input  logic [4:0]  rd,
        input  logic [31:0] rdata,
        input  int          rdy_dly,
        input  int          vld_dly,
        output logic        o_err,
        output logic        o_rd_we,
        output logic [4:0]  o_rd_addr,
        output logic [31:0] o_rd_data,
        output int          o_cycles,
        output int          o_req_cycles,
        output logic        o_req_done,
        output logic [31:0] o_addr,
        output logic [3:0]  o_wstrb,
        output logic [31:0] o_wdata,
        output logic        o_we,
        output logic        o_stable
    );
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic        w0, first, acc;
        int          rcnt, vcnt;
        is_store   = st;
        funct3     = f3;
        base       = b;
        imm        = i;
        store_data = sd;
        rd_in      = rd;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
        o_cycles = 1; o_req_cycles = 0; o_stable = 1'b1;
        o_addr = 32'h0; o_wstrb = 4'h0; o_wdata = 32'h0; o_we = 1'b0;
        a0 = 32'h0; d0 = 32'h0; s0 = 4'h0; w0 = 1'b0;
        first = 1'b1; acc = 1'b0; rcnt = 0; vcnt = 0;
        while (done !== 1'b1 && o_cycles < 400) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hCAFEF00D;
            if (mem_req === 1'b1) begin
                o_req_cycles++;
                if (first) begin
                    a0 = mem_addr; s0 = mem_wstrb; d0 = mem_wdata; w0 = mem_we;
                    first = 1'b0;
                end else if (mem_addr !== a0 || mem_wstrb !== s0 || mem_wdata !== d0 || mem_we !== w0) begin
                    o_stable = 1'b0;
                end
            end
            if (!acc) begin
                if (mem_req === 1'b1 && rcnt == rdy_dly) begin
                    mem_ready = 1'b1;
                    acc = 1'b1;
                    o_addr = mem_addr; o_wstrb = mem_wstrb; o_wdata = mem_wdata; o_we = mem_we;
                    if (vld_dly == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end
                end
                rcnt++;
            end else begin
                vcnt++;
                if (vcnt == vld_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                end
            end
            cyc();
            o_cycles++;
        end
        o_err      = err;
        o_rd_we    = rd_we;
        o_rd_addr  = rd_addr;
        o_rd_data  = rd_data;
        o_req_done = mem_req;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        cyc();
    endtask

    logic        r_err, r_we, r_reqd, r_mwe, r_stab;
    logic [4:0]  r_rda;
    logic [31:0] r_rdd, r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    int          r_cyc, r_req;

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
        n_chk++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else n_pass++;
        n_chk++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b exp=0", mem_we); else n_pass++;
        n_chk++; if (rd_we !== 1'b0) $display("FAIL reset_rd_we got=%b exp=0", rd_we); else n_pass++;
        n_chk++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); else n_pass++;
        n_chk++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got=%h exp=0", rd_data); else n_pass++;
        n_chk++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else n_pass++;
        n_chk++; if (mem_wstrb !== 4'h0) $display("FAIL reset_mem_wstrb got=%b exp=0000", mem_wstrb); else n_pass++;
        n_chk++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); else n_pass++;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_store_word();
        run_access(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd3, 32'h0, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_addr !== 32'h104) $display("FAIL sw_addr got=%h exp=104", r_addr); else n_pass++;
        n_chk++; if (r_wstrb !== 4'b1111) $display("FAIL sw_wstrb got=%b exp=1111", r_wstrb); else n_pass++;
        n_chk++; if (r_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata got=%h exp=deadbeef", r_wdata); else n_pass++;
        n_chk++; if (r_mwe !== 1'b1) $display("FAIL sw_we got=%b exp=1", r_mwe); else n_pass++;
        n_chk++; if (r_cyc != 2) $display("FAIL sw_latency got=%0d exp=2", r_cyc); else n_pass++;
        n_chk++; if (r_err !== 1'b0) $display("FAIL sw_err got=%b exp=0", r_err); else n_pass++;
        n_chk++; if (r_we !== 1'b0) $display("FAIL sw_rd_we got=%b exp=0", r_we); else n_pass++;
        n_chk++; if (r_rdd !== 32'h0) $display("FAIL sw_rd_data got=%h exp=0", r_rdd); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL sw_idle_after got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_store_byte_half();
        // SB to ea 0x203 with two wait states before ready.
        run_access(1'b1, 3'b000, 32'h200, 32'h3, 32'h000000A5, 5'd0, 32'h0, 2, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_addr !== 32'h200) $display("FAIL sb_addr got=%h exp=200", r_addr); else n_pass++;
        n_chk++; if (r_wstrb !== 4'b1000) $display("FAIL sb_wstrb got=%b exp=1000", r_wstrb); else n_pass++;
        n_chk++; if (r_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata got=%h exp=a5a5a5a5", r_wdata); else n_pass++;
        n_chk++; if (r_stab !== 1'b1) $display("FAIL sb_hold_stable got=%b exp=1", r_stab); else n_pass++;
        n_chk++; if (r_cyc != 4) $display("FAIL sb_latency got=%0d exp=4", r_cyc); else n_pass++;
        // SH to ea 0x1002 with negative offset: 0x1006 + (-4).
        run_access(1'b1, 3'b001, 32'h1006, 32'hFFFFFFFC, 32'h1234BEEF, 5'd0, 32'h0, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_addr !== 32'h1000) $display("FAIL sh_addr got=%h exp=1000", r_addr); else n_pass++;
        n_chk++; if (r_wstrb !== 4'b1100) $display("FAIL sh_wstrb got=%b exp=1100", r_wstrb); else n_pass++;
        n_chk++; if (r_wdata !== 32'hBEEFBEEF) $display("FAIL sh_wdata got=%h exp=beefbeef", r_wdata); else n_pass++;
        // Address wrap: 0xFFFFFFFE + 6 = 0x4.
        run_access(1'b1, 3'b000, 32'hFFFFFFFE, 32'h6, 32'h0000003C, 5'd0, 32'h0, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_addr !== 32'h4) $display("FAIL wrap_addr got=%h exp=4", r_addr); else n_pass++;
        n_chk++; if (r_wstrb !== 4'b0001) $display("FAIL wrap_wstrb got=%b exp=0001", r_wstrb); else n_pass++;
    endtask

    task automatic test_loads();
        // LB ea 0x301, rvalid three cycles after ready.
        run_access(1'b0, 3'b000, 32'h300, 32'h1, 32'hFFFFFFFF, 5'd5, 32'h00008000, 0, 3,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_rdd !== 32'hFFFFFF80) $display("FAIL lb_data got=%h exp=ffffff80", r_rdd); else n_pass++;
        n_chk++; if (r_we !== 1'b1) $display("FAIL lb_rd_we got=%b exp=1", r_we); else n_pass++;
        n_chk++; if (r_rda !== 5'd5) $display("FAIL lb_rd_addr got=%0d exp=5", r_rda); else n_pass++;
        n_chk++; if (r_cyc != 5) $display("FAIL lb_latency got=%0d exp=5", r_cyc); else n_pass++;
        n_chk++; if (r_req != 1) $display("FAIL lb_req_cycles got=%0d exp=1", r_req); else n_pass++;
        n_chk++; if (r_wstrb !== 4'b0000 || r_mwe !== 1'b0) $display("FAIL lb_bus_write got=%b/%b exp=0000/0", r_wstrb, r_mwe); else n_pass++;
        n_chk++; if (r_addr !== 32'h300) $display("FAIL lb_addr got=%h exp=300", r_addr); else n_pass++;
        run_access(1'b0, 3'b100, 32'h300, 32'h1, 32'h0, 5'd5, 32'h00008000, 0, 3,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_rdd !== 32'h00000080) $display("FAIL lbu_data got=%h exp=00000080", r_rdd); else n_pass++;
        // LH / LHU upper half, same-cycle rvalid.
        run_access(1'b0, 3'b001, 32'h600, 32'h2, 32'h0, 5'd9, 32'h87654321, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_rdd !== 32'hFFFF8765) $display("FAIL lh_data got=%h exp=ffff8765", r_rdd); else n_pass++;
        n_chk++; if (r_cyc != 2) $display("FAIL lh_latency got=%0d exp=2", r_cyc); else n_pass++;
        run_access(1'b0, 3'b101, 32'h600, 32'h2, 32'h0, 5'd9, 32'h87654321, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_rdd !== 32'h00008765) $display("FAIL lhu_data got=%h exp=00008765", r_rdd); else n_pass++;
        // LW to x7 and LW to x0.
        run_access(1'b0, 3'b010, 32'h4F0, 32'h10, 32'h0, 5'd7, 32'h12345678, 1, 1,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_rdd !== 32'h12345678) $display("FAIL lw_data got=%h exp=12345678", r_rdd); else n_pass++;
        n_chk++; if (r_addr !== 32'h500) $display("FAIL lw_addr got=%h exp=500", r_addr); else n_pass++;
        run_access(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 5'd0, 32'h12345678, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_cyc != 2) $display("FAIL lw_x0_done got=%0d exp=2", r_cyc); else n_pass++;
        n_chk++; if (r_we !== 1'b0) $display("FAIL lw_x0_rd_we got=%b exp=0", r_we); else n_pass++;
        n_chk++; if (r_err !== 1'b0) $display("FAIL lw_x0_err got=%b exp=0", r_err); else n_pass++;
    endtask

    task automatic test_illegal();
        run_access(1'b0, 3'b010, 32'h400, 32'h2, 32'h0, 5'd4, 32'h0, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_cyc != 1) $display("FAIL lw_mis_latency got=%0d exp=1", r_cyc); else n_pass++;
        n_chk++; if (r_err !== 1'b1) $display("FAIL lw_mis_err got=%b exp=1", r_err); else n_pass++;
        n_chk++; if (r_req != 0) $display("FAIL lw_mis_req got=%0d exp=0", r_req); else n_pass++;
        n_chk++; if (r_we !== 1'b0 || r_rdd !== 32'h0) $display("FAIL lw_mis_wb got=%b/%h exp=0/0", r_we, r_rdd); else n_pass++;
        run_access(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 5'd4, 32'h0, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_err !== 1'b1 || r_req != 0) $display("FAIL ld_f3_011 got=%b/%0d exp=1/0", r_err, r_req); else n_pass++;
        run_access(1'b1, 3'b001, 32'h701, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_err !== 1'b1 || r_req != 0) $display("FAIL sh_mis got=%b/%0d exp=1/0", r_err, r_req); else n_pass++;
        run_access(1'b1, 3'b100, 32'h700, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_err !== 1'b1 || r_req != 0) $display("FAIL st_f3_100 got=%b/%0d exp=1/0", r_err, r_req); else n_pass++;
        // LBU to an odd address is legal.
        run_access(1'b0, 3'b100, 32'h703, 32'h0, 32'h0, 5'd2, 32'hF1000000, 0, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_err !== 1'b0 || r_rdd !== 32'h000000F1) $display("FAIL lbu_odd got=%b/%h exp=0/000000f1", r_err, r_rdd); else n_pass++;
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'b010, 32'h800, 32'h0, 32'h0, 5'd6, 32'h0, -1, 0,
                   r_err, r_we, r_rda, r_rdd, r_cyc, r_req, r_reqd, r_addr, r_wstrb, r_wdata, r_mwe, r_stab);
        n_chk++; if (r_req != 255) $display("FAIL to_req_cycles got=%0d exp=255", r_req); else n_pass++;
        n_chk++; if (r_cyc != 256) $display("FAIL to_latency got=%0d exp=256", r_cyc); else n_pass++;
        n_chk++; if (r_err !== 1'b1) $display("FAIL to_err got=%b exp=1", r_err); else n_pass++;
        n_chk++; if (r_reqd !== 1'b0) $display("FAIL to_req_dropped got=%b exp=0", r_reqd); else n_pass++;
        n_chk++; if (r_we !== 1'b0) $display("FAIL to_rd_we got=%b exp=0", r_we); else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        is_store = 1'b1; funct3 = 3'b010; base = 32'h900; imm = 32'h0;
        store_data = 32'h11112222; rd_in = 5'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_chk++; if (mem_req !== 1'b1) $display("FAIL rst_pre_req got=%b exp=1", mem_req); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_mid_req got=%b exp=0", mem_req); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_mid_done got=%b exp=0", done); else n_pass++;
        cyc();
        cyc();
        rst = 1'b1;
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_after_done got=%b/%b exp=0/0", done, busy); else n_pass++;
        cyc();
        // SW to 0x10, with start pulses of a different access while busy.
        is_store = 1'b1; funct3 = 3'b010; base = 32'h10; imm = 32'h0;
        store_data = 32'hA0B0C0D0; rd_in = 5'd0;
        start = 1'b1;
        cyc();
        is_store = 1'b0; funct3 = 3'b011; base = 32'h999;
        cyc();
        n_chk++; if (mem_addr !== 32'h10 || mem_we !== 1'b1) $display("FAIL busy_start_addr got=%h/%b exp=10/1", mem_addr, mem_we); else n_pass++;
        n_chk++; if (mem_wdata !== 32'hA0B0C0D0) $display("FAIL busy_start_wdata got=%h exp=a0b0c0d0", mem_wdata); else n_pass++;
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        start = 1'b0;
        n_chk++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL post_rst_sw got=%b/%b exp=1/0", done, err); else n_pass++;
        cyc();
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL post_rst_idle got=%b/%b exp=0/0", busy, done); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        base = 32'h0; imm = 32'h0; store_data = 32'h0; rd_in = 5'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_store_word();
        test_store_byte_half();
        test_loads();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
